// File: rtl/hs_acc_pkg.sv
// Shared types and defaults for the four-phase accumulating arbiter.
package hs_acc_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/hs_acc_arbiter_rr_arb2.sv
// Two-way round-robin selector: one-hot grant plus the pointer value to adopt if the grant is taken.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
            // Priority passes to whichever requester was not just served.
            if (gnt[0]) begin
                ptr_next = 1'b1;
            end else if (gnt[1]) begin
                ptr_next = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hs_acc_arbiter.sv
// Arbitrates two four-phase requesters, accumulating each granted operand until limit transfers complete.
module hs_acc_arbiter
    import hs_acc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stb0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             stb1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    input  logic [CNT_W-1:0] limit,
    output logic [WIDTH-1:0] AC,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    state_t     state;
    state_t     state_next;
    logic       ptr;
    logic       ptr_next;
    logic       gsel;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       arb_en;
    logic       grant;
    logic       stb_g;
    logic       release_ack;

    assign req = {stb1, stb0};

    rr_arb2 u_arb (
        .req      (req),
        .ptr      (ptr),
        .en       (arb_en),
        .gnt      (gnt),
        .ptr_next (ptr_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // The limit check wins over any pending strobe.
                if (!(count < limit)) begin
                    state_next = DONE;
                end else if (grant) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!stb_g) begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        arb_en      = (state == IDLE) && (count < limit);
        grant       = arb_en && (gnt != 2'b00);
        stb_g       = gsel ? stb1 : stb0;
        release_ack = (state == ACK) && !stb_g;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr   <= 1'b0;
            gsel  <= 1'b0;
            AC    <= '0;
            count <= '0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (grant) begin
                // Operand is captured only here; later data changes are ignored.
                AC    <= AC + (gnt[1] ? data1 : data0);
                count <= count + CNT_W'(1);
                ack0  <= gnt[0];
                ack1  <= gnt[1];
                gsel  <= gnt[1];
                ptr   <= ptr_next;
            end else if (release_ack) begin
                ack0 <= 1'b0;
                ack1 <= 1'b0;
            end
            if (state_next == DONE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_acc_arbiter.sv
// Directed scoreboard bench: expected grants are queued by stimulus and checked by a monitor on each ack rise.
module tb_hs_acc_arbiter;

    logic       clk;
    logic       resetn;
    logic       stb0;
    logic [7:0] data0;
    logic       ack0;
    logic       stb1;
    logic [7:0] data1;
    logic       ack1;
    logic [7:0] limit;
    logic [7:0] AC;
    logic [7:0] count;
    logic       done;

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] ac;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ack1_seen = 1'b0;
    logic p0 = 1'b0;
    logic p1 = 1'b0;

    hs_acc_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .stb0   (stb0),
        .data0  (data0),
        .ack0   (ack0),
        .stb1   (stb1),
        .data1  (data1),
        .ack1   (ack1),
        .limit  (limit),
        .AC     (AC),
        .count  (count),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] who, input int ac, input int cnt);
        exp_t e;
        e.who = who;
        e.ac  = 8'(ac);
        e.cnt = 8'(cnt);
        sb.push_back(e);
    endtask

    // Monitor: every rising ack is one grant and must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && ((ack0 && !p0) || (ack1 && !p1))) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant actual=%b required=none at %0t", {ack1, ack0}, $time);
                end else begin
                    e = sb.pop_front();
                    chk("grant_who", 32'({ack1, ack0}), 32'(e.who));
                    chk("grant_AC", 32'(AC), 32'(e.ac));
                    chk("grant_count", 32'(count), 32'(e.cnt));
                end
            end
            if (ack1) ack1_seen = 1'b1;
            p0 = ack0;
            p1 = ack1;
        end
    end

    task automatic wait_ack(input int who, input logic lvl, input string name);
        int n;
        n = 0;
        while ((((who == 0) ? ack0 : ack1) !== lvl) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (((who == 0) ? ack0 : ack1) !== lvl) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (timeout) at %0t", name,
                     (who == 0) ? ack0 : ack1, lvl, $time);
        end
    endtask

    // Full four-phase transfer; caller must be at a negedge.
    task automatic req_xfer(input int who, input logic [7:0] d);
        if (who == 0) begin data0 = d; stb0 = 1'b1; end
        else          begin data1 = d; stb1 = 1'b1; end
        wait_ack(who, 1'b1, "ack_rise");
        if (who == 0) stb0 = 1'b0;
        else          stb1 = 1'b0;
        wait_ack(who, 1'b0, "ack_fall");
    endtask

    task automatic do_reset(input logic [7:0] lim);
        resetn = 1'b0;
        stb0   = 1'b0;
        stb1   = 1'b0;
        data0  = '0;
        data1  = '0;
        limit  = lim;
        repeat (2) @(negedge clk);
        chk("rst_AC", 32'(AC), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_acks", 32'({ack1, ack0}), 0);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        stb0 = 1'b0; stb1 = 1'b0; data0 = '0; data1 = '0; limit = '0;
        @(negedge clk);

        // Single requester, limit 3.
        do_reset(8'd3);
        ack1_seen = 1'b0;
        push(2'b01, 5, 1);
        push(2'b01, 12, 2);
        push(2'b01, 21, 3);
        req_xfer(0, 8'd5);
        req_xfer(0, 8'd7);
        req_xfer(0, 8'd9);
        @(negedge clk);
        chk("single_done", 32'(done), 1);
        chk("single_AC", 32'(AC), 21);
        chk("single_count", 32'(count), 3);
        stb0 = 1'b1; data0 = 8'd50;
        repeat (3) @(negedge clk);
        chk("done_no_ack0", 32'(ack0), 0);
        chk("done_count_frozen", 32'(count), 3);
        chk("done_AC_frozen", 32'(AC), 21);
        stb0 = 1'b0;
        chk("single_ack1_never", 32'(ack1_seen), 0);

        // Contention: round-robin 0,1,0,1.
        do_reset(8'd4);
        push(2'b01, 1, 1);
        push(2'b10, 17, 2);
        push(2'b01, 18, 3);
        push(2'b10, 34, 4);
        fork
            begin req_xfer(0, 8'd1);  req_xfer(0, 8'd1);  end
            begin req_xfer(1, 8'd16); req_xfer(1, 8'd16); end
        join
        repeat (2) @(negedge clk);
        chk("rr_AC", 32'(AC), 34);
        chk("rr_done", 32'(done), 1);

        // Overflow wraps modulo 256.
        do_reset(8'd2);
        push(2'b01, 200, 1);
        push(2'b01, 44, 2);
        req_xfer(0, 8'd200);
        req_xfer(0, 8'd100);
        @(negedge clk);
        chk("ovf_AC", 32'(AC), 44);
        chk("ovf_count", 32'(count), 2);
        chk("ovf_done", 32'(done), 1);

        // limit=0: done after the first edge, no transfers.
        do_reset(8'd0);
        stb0 = 1'b1; data0 = 8'd9;
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        chk("zero_AC", 32'(AC), 0);
        chk("zero_count", 32'(count), 0);
        stb0 = 1'b0;

        // Limit lowered below count mid-run, with a strobe pending.
        do_reset(8'd5);
        push(2'b01, 3, 1);
        push(2'b01, 7, 2);
        req_xfer(0, 8'd3);
        req_xfer(0, 8'd4);
        limit = 8'd1; stb0 = 1'b1; data0 = 8'd50;
        @(negedge clk);
        chk("late_done", 32'(done), 1);
        chk("late_count", 32'(count), 2);
        chk("late_AC", 32'(AC), 7);
        stb0 = 1'b0;

        // Reset asserted while ack0 is high.
        do_reset(8'd5);
        push(2'b01, 10, 1);
        data0 = 8'd10; stb0 = 1'b1;
        wait_ack(0, 1'b1, "mid_ack_rise");
        resetn = 1'b0;
        #1;
        chk("midrst_ack0", 32'(ack0), 0);
        chk("midrst_AC", 32'(AC), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_done", 32'(done), 0);
        stb0 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        push(2'b01, 6, 1);
        req_xfer(0, 8'd6);
        chk("midrst_restart_count", 32'(count), 1);

        // Stale data during ACK; a requester 1 strobe withdrawn before service.
        do_reset(8'd5);
        push(2'b01, 3, 1);
        data0 = 8'd3; stb0 = 1'b1;
        wait_ack(0, 1'b1, "stale_ack_rise");
        data0 = 8'd99; stb1 = 1'b1; data1 = 8'd77;
        @(negedge clk);
        stb1 = 1'b0;
        @(negedge clk);
        chk("stale_ack1_low", 32'(ack1), 0);
        stb0 = 1'b0;
        wait_ack(0, 1'b0, "stale_ack_fall");
        repeat (3) @(negedge clk);
        chk("stale_AC", 32'(AC), 3);
        chk("withdrawn_count", 32'(count), 1);

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_acc_arbiter.md
HS_ACC_ARBITER -- requirements
Module: hs_acc_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 8, data and accumulator width.
- CNT_W, 8, transfer counter and limit width.

REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  sole clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- stb0  input  1  requester 0 strobe (four-phase).
- data0  input  WIDTH  requester 0 operand, valid while stb0=1.
- ack0  output  1  requester 0 acknowledge.
- stb1  input  1  requester 1 strobe.
- data1  input  WIDTH  requester 1 operand.
- ack1  output  1  requester 1 acknowledge.
- limit  input  CNT_W  number of transfers before done.
- AC  output  WIDTH  accumulator.
- count  output  CNT_W  completed grants.
- done  output  1  sticky completion flag.

REQ-003 All outputs SHALL be registered; no combinational path from input to output.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACK, DONE.

REQ-005 In IDLE with count >= limit, the next state SHALL be DONE; this check takes priority over any strobe.

REQ-006 In IDLE with count < limit and at least one stb high, the block SHALL grant exactly one requester per cycle and perform the grant actions below on the same edge, then enter ACK.
- AC <= AC + data_g (mod 2^WIDTH).
- count <= count + 1.
- ack_g <= 1.
- Latency: stb_g sampled high to ack_g high is 1 cycle.

REQ-007 Arbitration SHALL be round-robin.
- Priority pointer resets to requester 0.
- After each grant, the pointer moves to the other requester.
- When only one stb is high, that requester wins regardless of the pointer.

REQ-008 In ACK, ack_g SHALL hold 1 while stb_g=1.
- On the first cycle stb_g is sampled 0: ack_g <= 0, next state IDLE.
- A new grant SHALL be issued no earlier than the cycle after ack_g falls.

REQ-009 The non-granted requester's ack SHALL stay 0 throughout; its stb stays pending and SHALL be served next.

REQ-010 data_g SHALL be sampled only on the grant edge; later changes to data_g while ack_g=1 SHALL NOT affect AC.

REQ-011 In DONE:
- done=1, sticky until reset.
- No further grants; ack0=ack1=0.
- AC and count frozen.

REQ-012 count SHALL never wrap: it increments only while count < limit.

REQ-013 limit SHALL be compared every IDLE cycle.
- Lowering limit below count mid-run forces DONE at the next IDLE.
- limit=0 gives DONE on the first cycle after reset release, with no transfers.

REQ-014 A requester that drops stb before being granted SHALL simply not be served; there is no side effect.

Reset
REQ-015 While resetn=0, the block SHALL asynchronously force:
- state=IDLE, pointer=0
- AC=0, count=0
- ack0=ack1=0, done=0

REQ-016 Assertion of resetn mid-transfer SHALL abort the transfer immediately; no partial AC update is retained.

REQ-017 Reset deassertion SHALL be synchronous to clk externally; the first grant is possible on the first rising edge after release.

Structure
REQ-018 The shared package hs_acc_pkg SHALL hold:
- the state enum (IDLE, ACK, DONE)
- default WIDTH and CNT_W constants

REQ-019 Two-way round-robin selection SHALL live in one sub-module, rr_arb2.
- Inputs: req[1:0], ptr, en.
- Outputs: gnt one-hot, pointer update.

REQ-020 Accumulate, count and FSM logic SHALL remain in hs_acc_arbiter.

Verification
REQ-021 Single requester: limit=3; stb0 pulses with data0=5,7,9 using the full four-phase handshake -> AC=21, count=3, done=1; ack1 never high.

REQ-022 Contention: limit=4; stb0 and stb1 held high with data0=1, data1=16, each dropped after its ack -> grant order 0,1,0,1; AC=34.

REQ-023 Overflow: limit=2; data0=200 then data0=100 -> AC=44 (mod 256); count=2; done=1.

REQ-024 Zero and late limit:
- limit=0 -> done=1 one cycle after reset release; AC=0.
- limit=5 lowered to 1 after two transfers -> DONE at the next IDLE; count=2.

REQ-025 Reset mid-ACK: assert resetn=0 while ack0=1 -> ack0, AC, count and done all 0 immediately, without waiting for a clock edge; the handshake restarts cleanly after release.

REQ-026 Stale data: change data0 from 3 to 99 while ack0=1 -> AC reflects 3 only.
